uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Detects each completed frame (rising edge of the receiver's rx_ok level) and pushes the received byte into a synchronous circular FIFO.
- Presents a registered pop interface, occupancy, and status flags (overrun, parity-error capture) to the register/bus side.
- Flushed whenever the receiver is disabled.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (default 16).
- RD_DFT, 8'hFF, value of rd_data after reset and after flush.

Ports:
- clk  in  1  system clock, same domain as receiver
- rst_n  in  1  asynchronous active-low reset
- rx_en  in  1  receiver enable; low = synchronous flush
- rx_ok  in  1  receiver frame-done level; high for one full sample period, i.e. many clk cycles
- rxd_in  in  8  received byte from receiver
- parity_error_in  in  1  receiver sticky parity error level
- rd_data_flag  out  1  gate to receiver output mux; high while rx_ok is high
- rd_en  in  1  pop request, one clk per byte
- rd_data  out  8  popped byte (registered)
- rd_valid  out  1  one-cycle pulse, rd_data updated
- empty  out  1  level == 0
- full  out  1  level == 2**ADDR_W
- level  out  ADDR_W+1  entries stored
- overrun  out  1  sticky, byte dropped because FIFO full
- perr  out  1  sticky, receiver reported parity error
- clr_status  in  1  clears overrun and perr

Behaviour:
- Reset values:
  - rd_data = RD_DFT; rd_valid = 0; level = 0; empty = 1; full = 0; overrun = 0; perr = 0; rd_data_flag = 0.
  - Write pointer, read pointer and edge-detect registers = 0.
- rd_data_flag = rx_ok (combinational), so rxd_in is stable and valid while rx_ok is high.
- Push event:
  - rx_ok_q registers rx_ok; push = rx_ok & ~rx_ok_q & rx_en.
  - Exactly one push per frame regardless of rx_ok width.
  - The byte is taken from rxd_in in the push cycle.
- Pop event: pop = rd_en & ~empty.
  - rd_data <= mem[rd_ptr] one cycle later, with rd_valid = 1 for that one cycle.
  - rd_en while empty is ignored: no pointer change, rd_valid = 0, rd_data holds.
- Pointers are ADDR_W bits and wrap naturally from 2**ADDR_W-1 to 0. Level is tracked separately, with width ADDR_W+1.
- Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full boundary:
  - push while full and no pop: byte dropped, pointers and level unchanged, overrun <= 1.
  - push and pop in the same cycle while full: write accepted, level stays 2**ADDR_W, no overrun.
- Empty boundary: push and rd_en in the same cycle while empty: the write is accepted and the pop is ignored. The byte becomes readable the next cycle. No bypass.
- perr:
  - Set on a rising edge of parity_error_in (registered edge detect).
  - The receiver delivers no rx_ok for an errored frame, so nothing is pushed.
- clr_status clears overrun and perr.
  - If clr_status coincides with a set event, set wins.
- rx_en low is a synchronous flush, held every cycle while low:
  - Pointers = 0, level = 0, rd_data = RD_DFT, rd_valid = 0, overrun = 0, perr = 0.
  - No push and no pop while low.
- Asynchronous reset mid-operation returns all registers to reset values immediately.
- Memory contents are not reset.
- Status outputs (empty, full, level) are derived from registered level. They are valid the cycle after the causing push/pop.

Optional Feature:
- Macro: UART_RX_FIFO_THRESH_EN.
- Defined:
  - Adds input rx_thresh [ADDR_W:0] and output rx_irq.
  - rx_irq is registered: rx_irq <= (level >= rx_thresh) & (rx_thresh != 0) & rx_en. Reset value 0.
  - Threshold 0 disables the interrupt.
- Undefined: neither port exists, and there is no extra logic.

Test Plan:
- rx_ok held high 160 clk with rxd_in=8'hA5 → exactly one push: level=1, empty=0; rd_en pulse → next cycle rd_data=8'hA5, rd_valid=1, level=0, empty=1.
- 16 frames with bytes 8'h00..8'h0F → full=1, level=16; 17th frame 8'h55 → overrun=1, level=16; 16 pops return 00..0F in order; 8'h55 is never read.
- Full FIFO, rd_en asserted in the same cycle as the rx_ok rising edge (byte 8'h77) → no overrun, level=16; the 16th subsequent pop returns 8'h77.
- rd_en while empty → rd_valid stays 0, rd_data unchanged (8'hFF after reset); rx_ok edge plus rd_en in the same cycle while empty → level=1, no rd_valid.
- parity_error_in 0→1 → perr=1 and level unchanged; clr_status pulse → perr=0; clr_status coincident with a new overrun → overrun remains 1.
- 5 bytes queued, rx_en low for 1 cycle → level=0, empty=1, rd_data=8'hFF, overrun=0; (THRESH_EN) rx_thresh=4, push 4 bytes → rx_irq=1 one cycle after level reaches 4; one pop → rx_irq=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Register/bus-side pop and status bundle of the UART receive FIFO.
// master = bus side (issues pops/clears), slave = FIFO.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
) ();
   logic              rd_en;
   logic              clr_status;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              overrun;
   logic              perr;

   modport master (
      output rd_en, clr_status,
      input  rd_data, rd_valid, empty, full, level, overrun, perr
   );

   modport slave (
      input  rd_en, clr_status,
      output rd_data, rd_valid, empty, full, level, overrun, perr
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: one push per rx_ok rising edge, registered pop, sticky status.
// Optional level-threshold interrupt enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
   parameter int         ADDR_W = 4,
   parameter logic [7:0] RD_DFT = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_en,
   input  logic              rx_ok,
   input  logic [7:0]        rxd_in,
   input  logic              parity_error_in,
   output logic              rd_data_flag,
`ifdef UART_RX_FIFO_THRESH_EN
   input  logic [ADDR_W:0]   rx_thresh,
   output logic              rx_irq,
`endif
   uart_rx_fifo_if.slave     bus
);
   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam int              LW      = ADDR_W + 1;
   localparam logic [LW-1:0]   LVL_ONE = LW'(1);
   localparam logic [LW-1:0]   LVL_MAX = LW'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overrun_q, overrun_d;
   logic              perr_q, perr_d;
   logic              rx_ok_q, perr_in_q;

   logic empty_w, full_w, push, pop, wr_accept, ovr_set, perr_set;

   assign rd_data_flag = rx_ok;
   assign empty_w      = (level_q == '0);
   assign full_w       = (level_q == LVL_MAX);
   assign push         = rx_ok & ~rx_ok_q & rx_en;
   assign pop          = bus.rd_en & ~empty_w & rx_en;
   // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
   assign wr_accept    = push & (~full_w | pop);
   assign ovr_set      = push & full_w & ~pop;
   assign perr_set     = parity_error_in & ~perr_in_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overrun_d  = overrun_q;
      perr_d     = perr_q;
      if (!rx_en) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         rd_data_d = RD_DFT;
         overrun_d = 1'b0;
         perr_d    = 1'b0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
         end
         case ({wr_accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
         // Set events are applied after the clear so they take priority.
         if (bus.clr_status) begin
            overrun_d = 1'b0;
            perr_d    = 1'b0;
         end
         if (ovr_set)  overrun_d = 1'b1;
         if (perr_set) perr_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_data_q  <= RD_DFT;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         perr_q     <= 1'b0;
         rx_ok_q    <= 1'b0;
         perr_in_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
         perr_q     <= perr_d;
         rx_ok_q    <= rx_ok;
         perr_in_q  <= parity_error_in;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q] <= rxd_in;
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.level    = level_q;
   assign bus.empty    = empty_w;
   assign bus.full     = full_w;
   assign bus.overrun  = overrun_q;
   assign bus.perr     = perr_q;

`ifdef UART_RX_FIFO_THRESH_EN
   logic rx_irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_irq_q <= 1'b0;
      else        rx_irq_q <= (level_q >= rx_thresh) & (rx_thresh != '0) & rx_en;
   end

   assign rx_irq = rx_irq_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default build; threshold
// interrupt checks included when UART_RX_FIFO_THRESH_EN is defined).
module tb_uart_rx_fifo;
   localparam int ADDR_W = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_en = 1'b0;
   logic       rx_ok = 1'b0;
   logic [7:0] rxd_in = 8'h00;
   logic       parity_error_in = 1'b0;
   logic       rd_data_flag;
`ifdef UART_RX_FIFO_THRESH_EN
   logic [ADDR_W:0] rx_thresh = '0;
   logic            rx_irq;
`endif
   int total = 0;
   int bad   = 0;

   uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   uart_rx_fifo #(.ADDR_W(ADDR_W), .RD_DFT(8'hFF)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_en           (rx_en),
      .rx_ok           (rx_ok),
      .rxd_in          (rxd_in),
      .parity_error_in (parity_error_in),
      .rd_data_flag    (rd_data_flag),
`ifdef UART_RX_FIFO_THRESH_EN
      .rx_thresh       (rx_thresh),
      .rx_irq          (rx_irq),
`endif
      .bus             (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] b);
      rxd_in = b;
      rx_ok  = 1'b1;
      repeat (3) step();
      rx_ok = 1'b0;
      step();
   endtask

   task automatic test_reset();
      bus.rd_en = 1'b0;
      bus.clr_status = 1'b0;
      repeat (3) step();
      total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL reset_rd_data got=%h exp=ff", bus.rd_data); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
      total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      total++; if ({bus.overrun, bus.perr} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", {bus.overrun, bus.perr}); end
      total++; if (rd_data_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b exp=0", rd_data_flag); end
      rst_n = 1'b1;
      rx_en = 1'b1;
      step();
   endtask

   task automatic test_empty_rd();
      bus.rd_en = 1'b1;
      step();
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL empty_pop_valid got=%b exp=0", bus.rd_valid); end
      total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL empty_pop_data got=%h exp=ff", bus.rd_data); end
      total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL empty_pop_level got=%0d exp=0", bus.level); end
      rxd_in = 8'h3C;
      rx_ok  = 1'b1;
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL empty_push_level got=%0d exp=1", bus.level); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL empty_push_valid got=%b exp=0", bus.rd_valid); end
      step();
      total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hFF) begin bad++; $display("FAIL empty_no_bypass got=%b/%h exp=0/ff", bus.rd_valid, bus.rd_data); end
      rx_ok = 1'b0;
      step();
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 8'h3C || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL empty_late_pop got=%h/%b exp=3c/1", bus.rd_data, bus.rd_valid); end
      step();
   endtask

   task automatic test_single_push();
      rxd_in = 8'hA5;
      rx_ok  = 1'b1;
      step();
      total++; if (rd_data_flag !== 1'b1) begin bad++; $display("FAIL flag_high got=%b exp=1", rd_data_flag); end
      repeat (159) step();
      rx_ok = 1'b0;
      step();
      total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL long_ok_level got=%0d exp=1", bus.level); end
      total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL long_ok_empty got=%b exp=0", bus.empty); end
      total++; if (rd_data_flag !== 1'b0) begin bad++; $display("FAIL flag_low got=%b exp=0", rd_data_flag); end
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 8'hA5) begin bad++; $display("FAIL pop_data got=%h exp=a5", bus.rd_data); end
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL pop_valid got=%b exp=1", bus.rd_valid); end
      total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL pop_level got=%0d/%b exp=0/1", bus.level, bus.empty); end
      step();
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL pop_valid_pulse got=%b exp=0", bus.rd_valid); end
   endtask

   task automatic test_full_overrun();
      for (int i = 0; i < 16; i++) frame(8'(i));
      total++; if (bus.full !== 1'b1 || bus.level !== 5'd16) begin bad++; $display("FAIL fill_full got=%b/%0d exp=1/16", bus.full, bus.level); end
      total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL fill_overrun got=%b exp=0", bus.overrun); end
      frame(8'h55);
      total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
      total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL overrun_level got=%0d exp=16", bus.level); end
      bus.rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         total++; if (bus.rd_data !== 8'(i) || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, bus.rd_data, bus.rd_valid, 8'(i)); end
      end
      bus.rd_en = 1'b0;
      step();
      total++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b/%b exp=1/0", bus.empty, bus.rd_valid); end
      bus.clr_status = 1'b1;
      step();
      bus.clr_status = 1'b0;
      total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b exp=0", bus.overrun); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 16; i++) frame(8'h20 + 8'(i));
      rxd_in    = 8'h77;
      rx_ok     = 1'b1;
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 8'h20) begin bad++; $display("FAIL simul_pop got=%h exp=20", bus.rd_data); end
      total++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin bad++; $display("FAIL simul_level got=%0d/%b exp=16/1", bus.level, bus.full); end
      total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun got=%b exp=0", bus.overrun); end
      repeat (2) step();
      rx_ok = 1'b0;
      step();
      bus.rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         total++; if (bus.rd_data !== ((i == 15) ? 8'h77 : 8'h21 + 8'(i))) begin bad++; $display("FAIL simul_drain_%0d got=%h", i, bus.rd_data); end
      end
      bus.rd_en = 1'b0;
      step();
      total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL simul_empty got=%0d exp=0", bus.level); end
   endtask

   task automatic test_status();
      parity_error_in = 1'b1;
      step();
      total++; if (bus.perr !== 1'b1) begin bad++; $display("FAIL perr_set got=%b exp=1", bus.perr); end
      total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL perr_level got=%0d exp=0", bus.level); end
      bus.clr_status = 1'b1;
      step();
      bus.clr_status = 1'b0;
      total++; if (bus.perr !== 1'b0) begin bad++; $display("FAIL perr_clr got=%b exp=0", bus.perr); end
      step();
      total++; if (bus.perr !== 1'b0) begin bad++; $display("FAIL perr_level_hold got=%b exp=0", bus.perr); end
      for (int i = 0; i < 16; i++) frame(8'h80 + 8'(i));
      rxd_in         = 8'h99;
      rx_ok          = 1'b1;
      bus.clr_status = 1'b1;
      step();
      bus.clr_status = 1'b0;
      total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL clr_vs_overrun got=%b exp=1", bus.overrun); end
      parity_error_in = 1'b0;
      step();
      parity_error_in = 1'b1;
      rx_ok = 1'b0;
      step();
      total++; if (bus.perr !== 1'b1) begin bad++; $display("FAIL perr_reset_again got=%b exp=1", bus.perr); end
   endtask

   task automatic test_flush();
      rx_en = 1'b0;
      step();
      rx_en = 1'b1;
      parity_error_in = 1'b0;
      total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL flush1_level got=%0d/%b/%b exp=0/1/0", bus.level, bus.empty, bus.full); end
      total++; if (bus.overrun !== 1'b0 || bus.perr !== 1'b0) begin bad++; $display("FAIL flush1_status got=%b/%b exp=0/0", bus.overrun, bus.perr); end
      total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL flush1_rd_data got=%h exp=ff", bus.rd_data); end
      for (int i = 1; i <= 5; i++) frame(8'h40 + 8'(i));
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      frame(8'h46);
      total++; if (bus.level !== 5'd5 || bus.rd_data !== 8'h41) begin bad++; $display("FAIL queue5 got=%0d/%h exp=5/41", bus.level, bus.rd_data); end
      rx_en = 1'b0;
      step();
      rx_en = 1'b1;
      total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL flush2_level got=%0d/%b exp=0/1", bus.level, bus.empty); end
      total++; if (bus.rd_data !== 8'hFF || bus.overrun !== 1'b0) begin bad++; $display("FAIL flush2_data got=%h/%b exp=ff/0", bus.rd_data, bus.overrun); end
      frame(8'h5A);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      total++; if (bus.rd_data !== 8'h5A || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL post_flush_pop got=%h/%b exp=5a/1", bus.rd_data, bus.rd_valid); end
      step();
   endtask

`ifdef UART_RX_FIFO_THRESH_EN
   task automatic test_thresh();
      rx_thresh = 5'd4;
      for (int i = 0; i < 3; i++) frame(8'h60 + 8'(i));
      total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL irq_below got=%b exp=0", rx_irq); end
      rxd_in = 8'h63;
      rx_ok  = 1'b1;
      step();
      total++; if (bus.level !== 5'd4 || rx_irq !== 1'b0) begin bad++; $display("FAIL irq_lag got=%0d/%b exp=4/0", bus.level, rx_irq); end
      step();
      total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", rx_irq); end
      rx_ok = 1'b0;
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      step();
      total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", rx_irq); end
      rx_thresh = 5'd0;
      step();
      step();
      total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b exp=0", rx_irq); end
   endtask
`endif

   task automatic test_async_reset();
      frame(8'hC3);
      total++; if (bus.level === 5'd0) begin bad++; $display("FAIL areset_pre got=%0d exp=nonzero", bus.level); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'hFF) begin bad++; $display("FAIL areset_now got=%0d/%b/%h exp=0/1/ff", bus.level, bus.empty, bus.rd_data); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_empty_rd();
      test_single_push();
      test_full_overrun();
      test_full_simul();
      test_status();
      test_flush();
`ifdef UART_RX_FIFO_THRESH_EN
      test_thresh();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
